// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and the
// execute-stage ALU it borrows.
package muldiv_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/alu.sv
// Execute-stage ALU. Lives in the parent stage; the sequencer drives its
// inputs through a mux while busy and consumes y combinationally.
module alu
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   // Opcode decode; unknown opcodes produce zero
   always_comb begin
      y = '0;
      case (op)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_SLT: y = {{(WIDTH-1){1'b0}}, (a < b)};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MULTU/DIVU sequencer. One shift-add (multiply) or
// restoring shift-subtract (divide) step per cycle, using the shared ALU.
// {hi,lo} is the working register pair and ends up as the result.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic             div_q;
   logic [WIDTH-1:0] opnd;
   logic [CW-1:0]    cnt;

   // Divide partial remainder: shift the next dividend bit in from lo
   logic [WIDTH-1:0] r;
   logic             msb;
   assign r   = {hi[WIDTH-2:0], lo[WIDTH-1]};
   assign msb = hi[WIDTH-1];

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // ALU operand steering; parked at add 0+0 outside RUN
   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (state == RUN) begin
         if (div_q) begin
            alu_op = ALU_SUB;
            alu_a  = r;
         end else begin
            alu_a  = hi;
         end
         alu_b = opnd;
      end
   end

   // Step datapath: the ALU is only WIDTH wide, so the add carry is
   // recovered by the wrap-around compare and the divide borrow by the
   // 33-bit trial compare (msb set means r really exceeds any divisor)
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             take;
   always_comb begin
      sum   = hi;
      carry = 1'b0;
      if (lo[0]) begin
         sum   = alu_y;
         carry = (alu_y < hi);
      end
      take = msb || (r >= opnd);
   end

   // Sequencer FSM and working registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         div_q <= 1'b0;
         opnd  <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (state == RUN) begin
         if (div_q) begin
            hi <= take ? alu_y : r;
            lo <= {lo[WIDTH-2:0], take};
         end else begin
            hi <= {carry, sum[WIDTH-1:1]};
            lo <= {sum[0], lo[WIDTH-1:1]};
         end
         cnt <= cnt + 1'b1;
         if (cnt == LAST) state <= DONE;
      end else if (start) begin
         // accepted from IDLE or DONE; DONE->RUN skips the IDLE bubble
         state <= RUN;
         div_q <= div;
         opnd  <= b;
         cnt   <= '0;
         hi    <= '0;
         lo    <= a;
      end else if (state == DONE) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with the shared ALU behind a busy mux.
// Stimulus pushes expected {hi,lo} into a scoreboard; a negedge monitor
// pops and compares on every done pulse.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         div = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;
   logic [2:0]   seq_op;
   logic [W-1:0] seq_a, seq_b, alu_y;

   // pipeline-side ALU operands, displaced while the sequencer is busy
   logic [2:0]   pipe_op = ALU_OR;
   logic [W-1:0] pipe_a  = 32'h1234_0000;
   logic [W-1:0] pipe_b  = 32'h0000_5678;
   logic [2:0]   m_op;
   logic [W-1:0] m_a, m_b;

   assign m_op = busy ? seq_op : pipe_op;
   assign m_a  = busy ? seq_a  : pipe_a;
   assign m_b  = busy ? seq_b  : pipe_b;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .div(div), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo),
      .alu_op(seq_op), .alu_a(seq_a), .alu_b(seq_b), .alu_y(alu_y)
   );

   alu #(.WIDTH(W)) u_alu (.op(m_op), .a(m_a), .b(m_b), .y(alu_y));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            res_t e;
            e = sb.pop_front();
            chk("result_hi", {32'd0, hi}, {32'd0, e.hi});
            chk("result_lo", {32'd0, lo}, {32'd0, e.lo});
         end
      end
   end

   // Present a request at the current (negedge) time; expected result queued
   task automatic issue(input logic d, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
      res_t e;
      start = 1'b1; div = d; a = av; b = bv;
      e.hi = eh; e.lo = el;
      sb.push_back(e);
   endtask

   // Wait for done, counting edges and busy cycles; optionally pulse a
   // stray MULTU 3x3 request at negedge inj_at while running
   task automatic wait_done(input string nm, input int inj_at);
      int edges = 0;
      int busyc = 0;
      do begin
         @(negedge clk);
         edges++;
         if (busy) busyc++;
         if (edges == 1) start = 1'b0;
         if (inj_at != 0 && edges == inj_at) begin
            start = 1'b1; div = 1'b0; a = 32'd3; b = 32'd3;
         end
         if (inj_at != 0 && edges == inj_at + 1) start = 1'b0;
      end while (!done && edges < 100);
      chk({nm, "_latency"}, 64'(edges), 64'd33);
      chk({nm, "_busy_cycles"}, 64'(busyc), 64'd32);
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_alu_op", {61'd0, seq_op}, {61'd0, ALU_ADD});
      chk("rst_alu_ab", {seq_a, seq_b}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // MULTU 7x6, then hold and idle-ALU checks
      @(negedge clk);
      issue(1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
      wait_done("mul_7x6", 0);
      @(negedge clk);
      chk("hold_hilo", {hi, lo}, 64'd42);
      chk("idle_busy_done", {62'd0, busy, done}, 64'd0);
      chk("idle_alu", {29'd0, seq_op, seq_a}, {29'd0, ALU_ADD, 32'd0});

      // carry recovery
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      wait_done("mul_max", 0);

      @(negedge clk);
      issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
      wait_done("div_100_7", 0);

      @(negedge clk);
      issue(1'b1, 32'h8000_0000, 32'd3, 32'd2, 32'h2AAA_AAAA);
      wait_done("div_msb", 0);

      // divide by zero
      @(negedge clk);
      issue(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      wait_done("div_zero", 0);

      // stray start mid-RUN ignored, then back-to-back start held in DONE
      @(negedge clk);
      issue(1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
      wait_done("div_inj", 12);
      issue(1'b0, 32'd3, 32'd3, 32'd0, 32'd9);
      wait_done("mul_b2b", 0);

      // async reset mid-operation (nothing queued for the aborted op)
      @(negedge clk);
      start = 1'b1; div = 1'b0; a = 32'd7; b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(1'b0, 32'd2, 32'd3, 32'd0, 32'd6);
      wait_done("mul_after_rst", 0);

      @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
